id_ex_stage: RTL and testbench

Decode-to-execute pipeline register and operand-forwarding stage of the 5-stage MIPS core. It captures decoded operands and control at each clock and honours stall, flush and reset. In the same cycle it resolves RAW hazards from MEM and WB and drives SrcAE, SrcBE and ALUControlE straight into the ALU. It also supplies the store data and destination register to the EX/MEM register.

---
 rtl/mips_pkg.sv | 43 ++++
 rtl/ex_fwd_unit.sv | 38 +++
 rtl/id_ex_stage.sv | 113 +++++++++++
 tb/tb_id_ex_stage.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: ALU opcodes, forward selects, widths
// and the ID/EX pipeline record.
package mips_pkg;

    localparam int XLEN = 32;
    localparam int RIDX = 5;

    typedef enum logic [2:0] {
        ALU_AND = 3'd0,
        ALU_OR  = 3'd1,
        ALU_ADD = 3'd2,
        ALU_SUB = 3'd3,
        ALU_SLL = 3'd4,
        ALU_SRL = 3'd5,
        ALU_SLT = 3'd6,
        ALU_LUI = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_W  = 2'd1,
        FWD_M  = 2'd2
    } fwd_sel_t;

    // An all-zero record is a NOP: no writes, ALU op AND.
    typedef struct packed {
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] sign_imm;
        logic [RIDX-1:0] shamt;
        logic [RIDX-1:0] rs;
        logic [RIDX-1:0] rt;
        logic [RIDX-1:0] rd;
        alu_op_t         alu_ctrl;
        logic            alu_src;
        logic            shift_imm;
        logic            reg_dst;
        logic            reg_write;
        logic            mem_write;
        logic            mem_to_reg;
    } id_ex_t;

endpackage

// File: rtl/ex_fwd_unit.sv
// One operand's RAW-hazard resolution: picks MEM, then WB, then the register
// file value, never forwarding writes to $0.
module ex_fwd_unit
    import mips_pkg::*;
(
    input  logic [RIDX-1:0] src,
    input  logic            RegWriteM,
    input  logic            RegWriteW,
    input  logic [RIDX-1:0] WriteRegM,
    input  logic [RIDX-1:0] WriteRegW,
    input  logic [XLEN-1:0] rd,
    input  logic [XLEN-1:0] ALUOutM,
    input  logic [XLEN-1:0] ResultW,
    output logic [1:0]      sel,
    output logic [XLEN-1:0] value
);

    fwd_sel_t fsel;

    always_comb begin
        fsel = FWD_RF;
        if (RegWriteM && (WriteRegM != '0) && (WriteRegM == src))
            fsel = FWD_M;
        else if (RegWriteW && (WriteRegW != '0) && (WriteRegW == src))
            fsel = FWD_W;
    end

    always_comb begin
        case (fsel)
            FWD_M:   value = ALUOutM;
            FWD_W:   value = ResultW;
            default: value = rd;
        endcase
    end

    assign sel = fsel;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with same-cycle operand forwarding feeding the ALU
// and the store-data / destination-register paths into EX/MEM.
module id_ex_stage
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] SignImmD,
    input  logic [RIDX-1:0] ShamtD,
    input  logic [RIDX-1:0] RsD,
    input  logic [RIDX-1:0] RtD,
    input  logic [RIDX-1:0] RdD,
    input  logic [2:0]      ALUControlD,
    input  logic            ALUSrcD,
    input  logic            ShiftImmD,
    input  logic            RegDstD,
    input  logic            RegWriteD,
    input  logic            MemWriteD,
    input  logic            MemtoRegD,
    input  logic [XLEN-1:0] ALUOutM,
    input  logic [XLEN-1:0] ResultW,
    input  logic [RIDX-1:0] WriteRegM,
    input  logic [RIDX-1:0] WriteRegW,
    input  logic            RegWriteM,
    input  logic            RegWriteW,
    output logic [XLEN-1:0] SrcAE,
    output logic [XLEN-1:0] SrcBE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] WriteDataE,
    output logic [RIDX-1:0] WriteRegE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            MemtoRegE,
    output logic [RIDX-1:0] RsE,
    output logic [RIDX-1:0] RtE,
    output logic [1:0]      ForwardAE,
    output logic [1:0]      ForwardBE
);

    id_ex_t d;
    id_ex_t e;
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;

    always_comb begin
        d            = '0;
        d.rd1        = RD1D;
        d.rd2        = RD2D;
        d.sign_imm   = SignImmD;
        d.shamt      = ShamtD;
        d.rs         = RsD;
        d.rt         = RtD;
        d.rd         = RdD;
        d.alu_ctrl   = alu_op_t'(ALUControlD);
        d.alu_src    = ALUSrcD;
        d.shift_imm  = ShiftImmD;
        d.reg_dst    = RegDstD;
        d.reg_write  = RegWriteD;
        d.mem_write  = MemWriteD;
        d.mem_to_reg = MemtoRegD;
    end

    // D -> E boundary: flush beats stall, reset beats both.
    always_ff @(posedge clk) begin
        if (reset || FlushE)
            e <= '0;
        else if (!StallE)
            e <= d;
    end

    ex_fwd_unit u_fwd_a (
        .src       (e.rs),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .WriteRegM (WriteRegM),
        .WriteRegW (WriteRegW),
        .rd        (e.rd1),
        .ALUOutM   (ALUOutM),
        .ResultW   (ResultW),
        .sel       (ForwardAE),
        .value     (fwd_a)
    );

    ex_fwd_unit u_fwd_b (
        .src       (e.rt),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .WriteRegM (WriteRegM),
        .WriteRegW (WriteRegW),
        .rd        (e.rd2),
        .ALUOutM   (ALUOutM),
        .ResultW   (ResultW),
        .sel       (ForwardBE),
        .value     (fwd_b)
    );

    // Immediate shifts take shamt zero-extended, so shift bit 5 stays clear.
    assign SrcAE       = e.shift_imm ? {{(XLEN-RIDX){1'b0}}, e.shamt} : fwd_a;
    assign SrcBE       = e.alu_src ? e.sign_imm : fwd_b;
    assign WriteDataE  = fwd_b;
    assign WriteRegE   = e.reg_dst ? e.rd : e.rt;
    assign ALUControlE = e.alu_ctrl;
    assign RegWriteE   = e.reg_write;
    assign MemWriteE   = e.mem_write;
    assign MemtoRegE   = e.mem_to_reg;
    assign RsE         = e.rs;
    assign RtE         = e.rt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a vector table for single-cycle behaviour
// plus hand sequences for reset, stall, flush and reset-during-stall.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, StallE, FlushE;
    logic [31:0] RD1D, RD2D, SignImmD, ALUOutM, ResultW;
    logic [4:0]  ShamtD, RsD, RtD, RdD, WriteRegM, WriteRegW;
    logic [2:0]  ALUControlD;
    logic        ALUSrcD, ShiftImmD, RegDstD, RegWriteD, MemWriteD, MemtoRegD;
    logic        RegWriteM, RegWriteW;
    logic [31:0] SrcAE, SrcBE, WriteDataE;
    logic [2:0]  ALUControlE;
    logic [4:0]  WriteRegE, RsE, RtE;
    logic        RegWriteE, MemWriteE, MemtoRegE;
    logic [1:0]  ForwardAE, ForwardBE;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
        .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD), .ShamtD(ShamtD),
        .RsD(RsD), .RtD(RtD), .RdD(RdD), .ALUControlD(ALUControlD),
        .ALUSrcD(ALUSrcD), .ShiftImmD(ShiftImmD), .RegDstD(RegDstD),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .MemtoRegD(MemtoRegD),
        .ALUOutM(ALUOutM), .ResultW(ResultW), .WriteRegM(WriteRegM),
        .WriteRegW(WriteRegW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .ALUControlE(ALUControlE),
        .WriteDataE(WriteDataE), .WriteRegE(WriteRegE), .RegWriteE(RegWriteE),
        .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE), .RsE(RsE), .RtE(RtE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE)
    );

    typedef struct packed {
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  shamt, rs, rt, rd;
        logic [2:0]  alu;
        logic        alusrc, shimm, regdst, regwr, memwr, memtoreg;
        logic [31:0] aluout_m, result_w;
        logic [4:0]  wreg_m, wreg_w;
        logic        rw_m, rw_w;
        logic [31:0] e_srca, e_srcb, e_wdata;
        logic [4:0]  e_wreg;
        logic [1:0]  e_fa, e_fb;
        logic        e_rw, e_mw, e_m2r;
        logic [2:0]  e_alu;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic zero_inputs();
        {RD1D, RD2D, SignImmD, ShamtD, RsD, RtD, RdD, ALUControlD} = '0;
        {ALUSrcD, ShiftImmD, RegDstD, RegWriteD, MemWriteD, MemtoRegD} = '0;
        {ALUOutM, ResultW, WriteRegM, WriteRegW, RegWriteM, RegWriteW} = '0;
    endtask

    task automatic drive(input vec_t v);
        RD1D = v.rd1; RD2D = v.rd2; SignImmD = v.imm; ShamtD = v.shamt;
        RsD = v.rs; RtD = v.rt; RdD = v.rd; ALUControlD = v.alu;
        ALUSrcD = v.alusrc; ShiftImmD = v.shimm; RegDstD = v.regdst;
        RegWriteD = v.regwr; MemWriteD = v.memwr; MemtoRegD = v.memtoreg;
        ALUOutM = v.aluout_m; ResultW = v.result_w; WriteRegM = v.wreg_m;
        WriteRegW = v.wreg_w; RegWriteM = v.rw_m; RegWriteW = v.rw_w;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".SrcAE"}, SrcAE, 32'h0);
        chk({tag, ".SrcBE"}, SrcBE, 32'h0);
        chk({tag, ".WriteDataE"}, WriteDataE, 32'h0);
        chk({tag, ".WriteRegE"}, 32'(WriteRegE), 32'h0);
        chk({tag, ".RsE"}, 32'(RsE), 32'h0);
        chk({tag, ".RtE"}, 32'(RtE), 32'h0);
        chk({tag, ".ALUControlE"}, 32'(ALUControlE), 32'h0);
        chk({tag, ".RegWriteE"}, 32'(RegWriteE), 32'h0);
        chk({tag, ".MemWriteE"}, 32'(MemWriteE), 32'h0);
        chk({tag, ".MemtoRegE"}, 32'(MemtoRegE), 32'h0);
        chk({tag, ".ForwardAE"}, 32'(ForwardAE), 32'h0);
        chk({tag, ".ForwardBE"}, 32'(ForwardBE), 32'h0);
    endtask

    task automatic build_vectors();
        vec_t v;
        // MEM beats WB on rs
        v = '0; v.rs = 3; v.rd1 = 5; v.alu = 3'd2;
        v.rw_m = 1; v.wreg_m = 3; v.aluout_m = 32'h1234;
        v.rw_w = 1; v.wreg_w = 3; v.result_w = 32'h9999;
        v.e_srca = 32'h1234; v.e_fa = 2; v.e_alu = 3'd2;
        vecs[0] = v;
        // WB only
        v.rw_m = 0; v.e_srca = 32'h9999; v.e_fa = 1;
        vecs[1] = v;
        // $0 never forwarded from MEM
        v = '0; v.rd2 = 32'h77; v.rw_m = 1; v.wreg_m = 0; v.aluout_m = 32'hDEAD;
        v.e_srcb = 32'h77; v.e_wdata = 32'h77;
        vecs[2] = v;
        // sll with immediate, forwarding on both operands still reported
        v = '0; v.shimm = 1; v.shamt = 31; v.rd1 = 32'hFFFF; v.alusrc = 1; v.imm = 32'h10;
        v.rs = 2; v.rt = 6; v.rd2 = 32'h1; v.alu = 3'd4;
        v.rw_m = 1; v.wreg_m = 6; v.aluout_m = 32'hABCD;
        v.rw_w = 1; v.wreg_w = 2; v.result_w = 32'h5555;
        v.e_srca = 32'h1F; v.e_srcb = 32'h10; v.e_wdata = 32'hABCD;
        v.e_wreg = 6; v.e_fa = 1; v.e_fb = 2; v.e_alu = 3'd4;
        vecs[3] = v;
        // RegDst selects rd
        v = '0; v.regdst = 1; v.rd = 9; v.rt = 4; v.regwr = 1; v.memtoreg = 1;
        v.rd1 = 32'h7; v.rd2 = 32'h42;
        v.e_srca = 32'h7; v.e_srcb = 32'h42; v.e_wdata = 32'h42;
        v.e_wreg = 9; v.e_rw = 1; v.e_m2r = 1;
        vecs[4] = v;
        // RegDst selects rt, store control
        v = '0; v.regdst = 0; v.rd = 9; v.rt = 4; v.memwr = 1; v.alu = 3'd7;
        v.rd2 = 32'hCAFE; v.e_srcb = 32'hCAFE; v.e_wdata = 32'hCAFE;
        v.e_wreg = 4; v.e_mw = 1; v.e_alu = 3'd7;
        vecs[5] = v;
        // A from WB, B from MEM at different indices
        v = '0; v.rs = 5; v.rt = 6; v.rd1 = 32'h1; v.rd2 = 32'h2;
        v.rw_m = 1; v.wreg_m = 6; v.aluout_m = 32'h22;
        v.rw_w = 1; v.wreg_w = 5; v.result_w = 32'h11;
        v.e_srca = 32'h11; v.e_srcb = 32'h22; v.e_wdata = 32'h22;
        v.e_wreg = 6; v.e_fa = 1; v.e_fb = 2;
        vecs[6] = v;
        // $0 never forwarded from WB; disabled MEM match ignored
        v = '0; v.rs = 0; v.rt = 8; v.rd1 = 32'h31; v.rd2 = 32'h32;
        v.rw_w = 1; v.wreg_w = 0; v.result_w = 32'hBAD0;
        v.rw_m = 0; v.wreg_m = 8; v.aluout_m = 32'hBAD1;
        v.e_srca = 32'h31; v.e_srcb = 32'h32; v.e_wdata = 32'h32; v.e_wreg = 8;
        vecs[7] = v;
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        build_vectors();

        // Reset with every D input high and no M/W writes
        reset = 1; StallE = 0; FlushE = 0;
        zero_inputs();
        {RD1D, RD2D, SignImmD, ALUOutM, ResultW} = {5{32'hFFFF_FFFF}};
        {ShamtD, RsD, RtD, RdD, WriteRegM, WriteRegW} = {6{5'h1F}};
        ALUControlD = 3'h7;
        {ALUSrcD, ShiftImmD, RegDstD, RegWriteD, MemWriteD, MemtoRegD} = 6'h3F;
        @(posedge clk); @(posedge clk); @(negedge clk);
        check_all_zero("reset");
        reset = 0;

        foreach (vecs[i]) begin
            string t;
            t = $sformatf("vec%0d", i);
            drive(vecs[i]);
            @(posedge clk); @(negedge clk);
            chk({t, ".SrcAE"}, SrcAE, vecs[i].e_srca);
            chk({t, ".SrcBE"}, SrcBE, vecs[i].e_srcb);
            chk({t, ".WriteDataE"}, WriteDataE, vecs[i].e_wdata);
            chk({t, ".WriteRegE"}, 32'(WriteRegE), 32'(vecs[i].e_wreg));
            chk({t, ".ForwardAE"}, 32'(ForwardAE), 32'(vecs[i].e_fa));
            chk({t, ".ForwardBE"}, 32'(ForwardBE), 32'(vecs[i].e_fb));
            chk({t, ".RegWriteE"}, 32'(RegWriteE), 32'(vecs[i].e_rw));
            chk({t, ".MemWriteE"}, 32'(MemWriteE), 32'(vecs[i].e_mw));
            chk({t, ".MemtoRegE"}, 32'(MemtoRegE), 32'(vecs[i].e_m2r));
            chk({t, ".ALUControlE"}, 32'(ALUControlE), 32'(vecs[i].e_alu));
            chk({t, ".RsE"}, 32'(RsE), 32'(vecs[i].rs));
            chk({t, ".RtE"}, 32'(RtE), 32'(vecs[i].rt));
        end

        // Capture, then stall three cycles while D inputs change
        zero_inputs();
        RegWriteD = 1; RD1D = 32'hAAAA; RsD = 7; ALUControlD = 3'd3; MemtoRegD = 1;
        @(posedge clk); @(negedge clk);
        chk("stall.load.RegWriteE", 32'(RegWriteE), 32'h1);
        chk("stall.load.SrcAE", SrcAE, 32'hAAAA);
        for (int i = 0; i < 3; i++) begin
            StallE = 1;
            RD1D = 32'(i + 100); RsD = 5'(i + 10); ALUControlD = 3'd5;
            RegWriteD = 0; MemtoRegD = 0; MemWriteD = 1;
            @(posedge clk); @(negedge clk);
            chk($sformatf("stall%0d.SrcAE", i), SrcAE, 32'hAAAA);
            chk($sformatf("stall%0d.RsE", i), 32'(RsE), 32'h7);
            chk($sformatf("stall%0d.RegWriteE", i), 32'(RegWriteE), 32'h1);
            chk($sformatf("stall%0d.MemWriteE", i), 32'(MemWriteE), 32'h0);
            chk($sformatf("stall%0d.ALUControlE", i), 32'(ALUControlE), 32'h3);
        end
        // Held operand tracks a new MEM producer without a clock edge
        RegWriteM = 1; WriteRegM = 7; ALUOutM = 32'h5151;
        #1;
        chk("stall.track.ForwardAE", 32'(ForwardAE), 32'h2);
        chk("stall.track.SrcAE", SrcAE, 32'h5151);

        // Stall and flush together: flush wins
        FlushE = 1;
        @(posedge clk); @(negedge clk);
        check_all_zero("flush");

        // Reset during a stall clears the registers
        FlushE = 0; StallE = 0;
        zero_inputs();
        RegWriteD = 1; RD1D = 32'h3333; RsD = 4; ALUControlD = 3'd6;
        @(posedge clk); @(negedge clk);
        chk("rststall.load.SrcAE", SrcAE, 32'h3333);
        StallE = 1; reset = 1;
        @(posedge clk); @(negedge clk);
        check_all_zero("rststall");
        reset = 0; StallE = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
